ram_ctrl: RTL and testbench

RAM_CTRL -- requirements
Module: ram_ctrl

---
 rtl/ram_ctrl_pkg.sv | 14 +
 rtl/ram_ctrl_mem.sv | 66 ++++++
 rtl/ram_ctrl.sv | 133 +++++++++++++
 tb/tb_ram_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the RAM controller.
// Parity option is selected with RAM_CTRL_PARITY_EN.
package ram_ctrl_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int ADDR_W_DEFAULT = 9;
    localparam int RSP_FIFO_DEPTH = 2;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

endpackage

// File: rtl/ram_ctrl_mem.sv
// Synchronous single-port RAM with byte-enable writes.
// Even parity per byte when RAM_CTRL_PARITY_EN is defined.
module ram_ctrl_mem
    import ram_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W/8-1:0] be,
    output logic [DATA_W-1:0] rdata
`ifdef RAM_CTRL_PARITY_EN
   ,output logic [DATA_W/8-1:0] perr
`endif
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < NB; i++) begin
                    if (be[i]) begin
                        mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

`ifdef RAM_CTRL_PARITY_EN
    logic [NB-1:0] par [DEPTH];
    logic [NB-1:0] rpar;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < NB; i++) begin
                    if (be[i]) begin
                        par[addr][i] <= ^wdata[i*8 +: 8];
                    end
                end
            end else begin
                rpar <= par[addr];
            end
        end
    end

    always_comb begin
        perr = '0;
        for (int i = 0; i < NB; i++) begin
            perr[i] = ^{rdata[i*8 +: 8], rpar[i]};
        end
    end
`endif

endmodule

// File: rtl/ram_ctrl.sv
// RAM controller: clear sweep, request flow control, 2-entry response FIFO.
// Optional parity checking enabled by RAM_CTRL_PARITY_EN.
module ram_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                init_done
`ifdef RAM_CTRL_PARITY_EN
   ,output logic [DATA_W/8-1:0] rsp_perr
`endif
);

    localparam int NB = DATA_W / 8;
    localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state, state_nxt;
    logic [ADDR_W:0]   cnt, cnt_inc;
    logic              inflight;
    logic [1:0]        count;
    logic              wp, rp;
    logic [DATA_W-1:0] fifo_d [RSP_FIFO_DEPTH];

    logic              accept, rd_acc, credit_ok;
    logic              fifo_empty, pop, push, fifo_pop;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata, head;
    logic [NB-1:0]     mem_be;

    assign cnt_inc    = cnt + ONE;
    assign accept     = req_valid & req_ready;
    assign rd_acc     = accept & ~req_write;
    assign fifo_empty = (count == 2'd0);
    assign credit_ok  = ({1'b0, count} + {2'b0, inflight}) < 3'd2;

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        init_done = 1'b0;
        unique case (state)
            INIT: begin
                // Carry into the top bit means every word has been cleared
                if (cnt_inc[ADDR_W]) state_nxt = RUN;
            end
            RUN: begin
                init_done = 1'b1;
                req_ready = credit_ok | req_write;
            end
        endcase
    end

    assign mem_en    = (state == INIT) | accept;
    assign mem_we    = (state == INIT) | req_write;
    assign mem_addr  = (state == INIT) ? cnt[ADDR_W-1:0] : req_addr;
    assign mem_wdata = (state == INIT) ? '0 : req_wdata;
    assign mem_be    = (state == INIT) ? '1 : req_be;

    // Empty FIFO lets the RAM output bypass straight to the consumer
    assign rsp_valid = (state == RUN) & (~fifo_empty | inflight);
    assign head      = fifo_empty ? mem_rdata : fifo_d[rp];
    assign rsp_rdata = rsp_valid ? head : '0;
    assign pop       = rsp_valid & rsp_ready;
    assign push      = inflight & ~(fifo_empty & rsp_ready);
    assign fifo_pop  = pop & ~fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= INIT;
            cnt      <= '0;
            inflight <= 1'b0;
            count    <= 2'd0;
            wp       <= 1'b0;
            rp       <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= rd_acc;
            if (state == INIT) cnt <= cnt_inc;
            if (push) wp <= ~wp;
            if (fifo_pop) rp <= ~rp;
            case ({push, fifo_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_d[wp] <= mem_rdata;
    end

`ifdef RAM_CTRL_PARITY_EN
    logic [NB-1:0] mem_perr;
    logic [NB-1:0] fifo_p [RSP_FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (push) fifo_p[wp] <= mem_perr;
    end

    assign rsp_perr = rsp_valid ?
        (fifo_empty ? mem_perr : fifo_p[rp]) : '0;
`endif

    ram_ctrl_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .en    (mem_en),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .be    (mem_be),
        .rdata (mem_rdata)
`ifdef RAM_CTRL_PARITY_EN
       ,.perr  (mem_perr)
`endif
    );

endmodule

// File: tb/tb_ram_ctrl.sv
// Scoreboard testbench for ram_ctrl (default 32-bit x 512 configuration).
// Parity scenario compiled in with RAM_CTRL_PARITY_EN.
module tb_ram_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [8:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        init_done;
`ifdef RAM_CTRL_PARITY_EN
    logic [3:0]  rsp_perr;
    logic [3:0]  last_perr = '0;
`endif

    int checks = 0;
    int errors = 0;
    int n_rsp = 0;
    logic [31:0] last_rdata = '0;
    logic [31:0] model [512];
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    ram_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .init_done (init_done)
`ifdef RAM_CTRL_PARITY_EN
       ,.rsp_perr  (rsp_perr)
`endif
    );

    // Scoreboard: handshakes seen half a cycle before the edge that takes them
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected got %h", rsp_rdata);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    if (rsp_rdata !== e) begin
                        errors++;
                        $display("FAIL rsp_data got %h exp %h", rsp_rdata, e);
                    end
                end
                last_rdata = rsp_rdata;
`ifdef RAM_CTRL_PARITY_EN
                last_perr = rsp_perr;
`endif
                n_rsp++;
            end
            if (req_valid && req_ready) begin
                if (req_write) begin
                    for (int i = 0; i < 4; i++)
                        if (req_be[i])
                            model[req_addr][i*8 +: 8] = req_wdata[i*8 +: 8];
                end else begin
                    exp_q.push_back(model[req_addr]);
                end
            end
        end
    end

    task automatic clear_model();
        for (int i = 0; i < 512; i++) model[i] = '0;
        exp_q.delete();
    endtask

    task automatic do_req(input logic w, input logic [8:0] a,
                          input logic [31:0] d, input logic [3:0] b);
        bit ok = 0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_be    = b;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (req_ready) ok = 1;
            @(posedge clk); #1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL req_timeout addr %h", a);
        end
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_write = 1'b0;
    endtask

    task automatic drain();
        bit ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0) ok = 1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout left %0d", exp_q.size());
        end
    endtask

    // Counts edges from release until init_done; expects exactly 512
    task automatic sweep_check(input string tag);
        int n = 0;
        int bad = 0;
        bit done = 0;
        @(negedge clk);
        rst_n = 1'b1;
        while (!done && n < 2000) begin
            @(posedge clk); #1;
            n++;
            if (init_done) done = 1;
            else if (req_ready || rsp_valid) bad++;
        end
        checks++;
        if (n !== 512) begin
            errors++;
            $display("FAIL %s_sweep_len got %0d exp 512", tag, n);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL %s_init_outputs got %0d exp 0", tag, bad);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if ({req_ready, rsp_valid, init_done} !== 3'b000 ||
            rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL %s_outputs got %b/%h exp 000/0", tag,
                     {req_ready, rsp_valid, init_done}, rsp_rdata);
        end
    endtask

    task automatic test_reset();
        clear_model();
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        sweep_check("reset");
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL run_ready got %b exp 1", req_ready);
        end
        last_rdata = '1;
        do_req(1'b0, 9'h1FF, '0, '0);
        idle();
        drain();
        checks++;
        if (last_rdata !== 32'h0) begin
            errors++;
            $display("FAIL read_1ff got %h exp 0", last_rdata);
        end
    endtask

    task automatic test_byte_enable();
        do_req(1'b1, 9'h010, 32'hDEADBEEF, 4'b1111);
        do_req(1'b1, 9'h010, 32'h000000AA, 4'b0001);
        do_req(1'b0, 9'h010, '0, '0);
        idle();
        drain();
        checks++;
        if (last_rdata !== 32'hDEADBEAA) begin
            errors++;
            $display("FAIL byte_en got %h exp deadbeaa", last_rdata);
        end
    endtask

    task automatic test_back_to_back();
        do_req(1'b1, 9'h020, 32'h12345678, 4'b1111);
        do_req(1'b0, 9'h020, '0, '0);
        idle();
        drain();
        checks++;
        if (last_rdata !== 32'h12345678) begin
            errors++;
            $display("FAIL raw_b2b got %h exp 12345678", last_rdata);
        end
    endtask

    task automatic test_backpressure();
        int base = n_rsp;
        int stalls = 0;
        int unstable = 0;
        bit ok = 0;
        do_req(1'b1, 9'h040, 32'hA0A00001, 4'hF);
        do_req(1'b1, 9'h041, 32'hA0A00002, 4'hF);
        do_req(1'b1, 9'h042, 32'hA0A00003, 4'hF);
        idle();
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_addr = 9'h040 + 9'(i);
            @(negedge clk);
            checks++;
            if (req_ready !== 1'b1) begin
                errors++;
                $display("FAIL bp_accept%0d got %b exp 1", i, req_ready);
            end
            @(posedge clk); #1;
        end
        req_addr = 9'h042;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (req_ready) stalls++;
            if (!rsp_valid || rsp_rdata !== 32'hA0A00001) unstable++;
        end
        checks++;
        if (stalls !== 0) begin
            errors++;
            $display("FAIL bp_third_ready got %0d exp 0", stalls);
        end
        checks++;
        if (unstable !== 0) begin
            errors++;
            $display("FAIL bp_hold got %0d exp 0", unstable);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (req_ready) ok = 1;
            @(posedge clk); #1;
        end
        idle();
        drain();
        checks++;
        if (!ok || n_rsp - base !== 3 || last_rdata !== 32'hA0A00003) begin
            errors++;
            $display("FAIL bp_release got %0d/%h exp 3/a0a00003",
                     n_rsp - base, last_rdata);
        end
    endtask

    task automatic test_stream();
        int base;
        int stalls = 0;
        for (int i = 0; i < 16; i++)
            do_req(1'b1, 9'h100 + 9'(i), $urandom, 4'($urandom));
        idle();
        base = n_rsp;
        req_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            req_addr = 9'h100 + 9'(i);
            @(negedge clk);
            if (!req_ready) stalls++;
            @(posedge clk); #1;
        end
        idle();
        drain();
        checks++;
        if (stalls !== 0 || n_rsp - base !== 16) begin
            errors++;
            $display("FAIL stream got stalls %0d rsp %0d exp 0/16",
                     stalls, n_rsp - base);
        end
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b0;
        do_req(1'b0, 9'h040, '0, '0);
        do_req(1'b0, 9'h041, '0, '0);
        idle();
        rst_n = 1'b0;
        #1 check_reset_outputs("run_reset");
        clear_model();
        rsp_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("sweep_reset");
        sweep_check("restart");
        last_rdata = '1;
        do_req(1'b0, 9'h040, '0, '0);
        idle();
        drain();
        checks++;
        if (last_rdata !== 32'h0) begin
            errors++;
            $display("FAIL cleared_after_reset got %h exp 0", last_rdata);
        end
    endtask

`ifdef RAM_CTRL_PARITY_EN
    task automatic test_parity();
        do_req(1'b1, 9'h030, 32'h11223344, 4'hF);
        idle();
        @(posedge clk); #1;
        dut.u_mem.mem[48][16] = ~dut.u_mem.mem[48][16];
        model[48] = model[48] ^ 32'h00010000;
        do_req(1'b0, 9'h030, '0, '0);
        idle();
        drain();
        checks++;
        if (last_perr !== 4'b0100) begin
            errors++;
            $display("FAIL parity got %b exp 0100", last_perr);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_byte_enable();
        test_back_to_back();
        test_backpressure();
        test_stream();
`ifdef RAM_CTRL_PARITY_EN
        test_parity();
`endif
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
